// File: rtl/ex_mem_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_skid_reg
// Brief    : EX->MEM pipeline register with a two-entry skid buffer and flush.
// Revision : 1.0
// ============================================================================
module ex_mem_skid_reg #(
    parameter int DWIDTH = 32,
    parameter int RADDR  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_alu_out,
    input  logic [DWIDTH-1:0] in_store_data,
    input  logic [DWIDTH-1:0] in_pc,
    input  logic [RADDR-1:0]  in_rd,
    input  logic              in_rd_we,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_alu_out,
    output logic [DWIDTH-1:0] out_store_data,
    output logic [DWIDTH-1:0] out_pc,
    output logic [RADDR-1:0]  out_rd,
    output logic              out_rd_we,
    output logic              out_mem_rd,
    output logic              out_mem_wr
);

    localparam int PW = 3*DWIDTH + RADDR + 3;

    // Encoding is {main_valid, skid_valid}; 2'b01 can never be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL1 = 2'b10,
        FULL2 = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic [PW-1:0]   in_pl;
    logic            in_xfer;
    logic            out_xfer;

    assign in_pl = {in_alu_out, in_store_data, in_pc, in_rd, in_rd_we, in_mem_rd, in_mem_wr};
    assign {out_alu_out, out_store_data, out_pc, out_rd, out_rd_we, out_mem_rd, out_mem_wr} = main_q;

    // Both handshake outputs come straight from state flops, so a downstream
    // stall never reaches in_ready in the same cycle.
    assign out_valid = state_q[1];
    assign in_ready  = ~state_q[0];

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_pl;
                        state_d = FULL1;
                    end
                end
                FULL1: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_pl;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        skid_d  = in_pl;
                        state_d = FULL2;
                    end
                end
                FULL2: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = FULL1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_skid_reg.sv
`default_nettype none
// Bench for ex_mem_skid_reg: directed scenarios then random traffic, all
// checked against a two-deep FIFO queue model.
module tb_ex_mem_skid_reg;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic        mr;
        logic        mw;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_out, out_store_data, out_pc;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_mem_rd, out_mem_wr;
    ent_t        cur_in;
    ent_t        obs_e;

    int checks = 0;
    int errors = 0;
    ent_t mq[$];

    assign obs_e = {out_alu_out, out_store_data, out_pc, out_rd, out_rd_we, out_mem_rd, out_mem_wr};

    ex_mem_skid_reg #(.DWIDTH(32), .RADDR(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_out     (cur_in.alu),
        .in_store_data  (cur_in.sd),
        .in_pc          (cur_in.pc),
        .in_rd          (cur_in.rd),
        .in_rd_we       (cur_in.we),
        .in_mem_rd      (cur_in.mr),
        .in_mem_wr      (cur_in.mw),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_out    (out_alu_out),
        .out_store_data (out_store_data),
        .out_pc         (out_pc),
        .out_rd         (out_rd),
        .out_rd_we      (out_rd_we),
        .out_mem_rd     (out_mem_rd),
        .out_mem_wr     (out_mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] alu, input logic [4:0] rd, input logic we);
        ent_t e;
        e.alu = alu;
        e.sd  = alu ^ 32'hA5A5_0000;
        e.pc  = 32'h0000_4000 + {alu[29:0], 2'b00};
        e.rd  = rd;
        e.we  = we;
        e.mr  = alu[0];
        e.mw  = alu[1];
        return e;
    endfunction

    // Model view: a FIFO of at most two entries; head is what the memory stage sees.
    task automatic check_all(input string tag);
        chk({tag, ".in_ready"}, in_ready, (mq.size() < 2));
        chk({tag, ".out_valid"}, out_valid, (mq.size() > 0));
        if (mq.size() > 0) chk({tag, ".payload"}, obs_e, mq[0]);
    endtask

    task automatic cycle();
        bit acc_in, acc_out;
        acc_in  = in_valid && (mq.size() < 2);
        acc_out = out_ready && (mq.size() > 0);
        if (flush) begin
            mq.delete();
        end else begin
            if (acc_out) void'(mq.pop_front());
            if (acc_in) mq.push_back(cur_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input ent_t e);
        in_valid = v;
        cur_in   = e;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cur_in = '0;
        #1;
        chk("rst.in_ready_held", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.payload", obs_e, '0);
        rst_n = 1'b1;

        // 1: single entry, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, mk(32'h0000_1234, 5'd5, 1'b1));
        cycle();
        drive(1'b0, '0);
        chk("t1.out_valid", out_valid, 1'b1);
        chk("t1.alu", out_alu_out, 32'h0000_1234);
        chk("t1.rd", out_rd, 5'd5);
        check_all("t1");
        cycle();
        chk("t1.drained", out_valid, 1'b0);

        // 2: back-to-back streaming
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, mk(32'(i * 16), 5'(i), 1'b1));
            check_all("t2");
            cycle();
            chk("t2.alu", out_alu_out, 32'(i * 16));
        end
        drive(1'b0, '0);
        check_all("t2.tail");
        cycle();
        check_all("t2.end");

        // 3/4: stall fill to FULL2, hold C until accepted
        out_ready = 1'b0;
        drive(1'b1, mk(32'h0000_AAAA, 5'd1, 1'b0));
        cycle();
        drive(1'b1, mk(32'h0000_BBBB, 5'd2, 1'b1));
        cycle();
        chk("t3.in_ready_low", in_ready, 1'b0);
        chk("t3.hold_a", out_alu_out, 32'h0000_AAAA);
        drive(1'b1, mk(32'h0000_CCCC, 5'd3, 1'b1));
        repeat (2) begin
            check_all("t4.stall");
            cycle();
        end
        chk("t4.stable_a", out_alu_out, 32'h0000_AAAA);
        out_ready = 1'b1;
        cycle();
        chk("t3.second_b", out_alu_out, 32'h0000_BBBB);
        chk("t3.in_ready_back", in_ready, 1'b1);
        check_all("t4.b");
        cycle();
        drive(1'b0, '0);
        chk("t4.third_c", out_alu_out, 32'h0000_CCCC);
        check_all("t4.c");
        cycle();
        check_all("t4.empty");

        // 5: flush in FULL2 with a simultaneous offer
        out_ready = 1'b0;
        drive(1'b1, mk(32'h0000_1111, 5'd4, 1'b1));
        cycle();
        drive(1'b1, mk(32'h0000_2222, 5'd6, 1'b1));
        cycle();
        check_all("t5.full2");
        flush = 1'b1;
        drive(1'b1, mk(32'h0000_DDDD, 5'd7, 1'b1));
        cycle();
        flush = 1'b0;
        drive(1'b0, '0);
        chk("t5.out_valid", out_valid, 1'b0);
        chk("t5.in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cycle();
        chk("t5.no_dddd", out_valid, 1'b0);

        // 6: async reset mid-stall
        out_ready = 1'b0;
        drive(1'b1, mk(32'h0000_3333, 5'd8, 1'b1));
        cycle();
        drive(1'b1, mk(32'h0000_4444, 5'd9, 1'b1));
        cycle();
        drive(1'b0, '0);
        check_all("t6.full2");
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        chk("t6.out_valid", out_valid, 1'b0);
        chk("t6.in_ready", in_ready, 1'b1);
        chk("t6.alu", out_alu_out, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("t6.after");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            ent_t e;
            e.alu = $urandom;
            e.sd  = $urandom;
            e.pc  = $urandom;
            e.rd  = 5'($urandom_range(0, 31));
            e.we  = 1'($urandom);
            e.mr  = 1'($urandom);
            e.mw  = 1'($urandom);
            drive(($urandom_range(0, 3) != 0), e);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            check_all("rnd");
            cycle();
        end
        flush = 1'b0;
        drive(1'b0, '0);
        check_all("rnd.end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
